// File: rtl/eca_engine.sv
// Elementary cellular automaton engine: WIDTH-cell row under any Wolfram rule,
// with run/pause, single-step, generation prescaler and generation counter.
module eca_engine #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 1,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             start_stop,
  input  logic             step,
  input  logic [7:0]       rule,
  input  logic             wrap,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             running,
  output logic [GEN_W-1:0] gen_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {PAUSE, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [GEN_W-1:0] r_gen, w_gen_nxt;
  logic [PW-1:0]    r_pre, w_pre_nxt;
  logic             r_ss_d, r_step_d;

  logic             w_ss_rise, w_step_rise;
  logic [WIDTH+1:0] w_ext;
  logic [WIDTH-1:0] w_evolve;

  assign w_ss_rise   = start_stop & ~r_ss_d;
  assign w_step_rise = step & ~r_step_d;

  // Row padded with its out-of-range neighbours: w_ext[i+1] is cell i
  assign w_ext = {wrap & r_q[0], r_q, wrap & r_q[WIDTH-1]};

  always_comb begin
    w_evolve = '0;
    for (int i = 0; i < WIDTH; i++)
      w_evolve[i] = rule[w_ext[i +: 3]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= PAUSE;
      r_q      <= '0;
      r_gen    <= '0;
      r_pre    <= '0;
      r_ss_d   <= 1'b0;
      r_step_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_gen    <= w_gen_nxt;
      r_pre    <= w_pre_nxt;
      r_ss_d   <= start_stop;
      r_step_d <= step;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_gen_nxt   = r_gen;
    w_pre_nxt   = r_pre;
    if (load) begin
      w_state_nxt = PAUSE;
      w_q_nxt     = data;
      w_gen_nxt   = '0;
      w_pre_nxt   = '0;
    end else if (w_ss_rise) begin
      w_state_nxt = (r_state == RUN) ? PAUSE : RUN;
      w_pre_nxt   = '0;
    end else if (r_state == RUN) begin
      if (r_pre == PRE_LAST) begin
        w_q_nxt   = w_evolve;
        w_gen_nxt = r_gen + GEN_W'(1);
        w_pre_nxt = '0;
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end else if (w_step_rise) begin
      w_q_nxt   = w_evolve;
      w_gen_nxt = r_gen + GEN_W'(1);
    end
  end

  assign q         = r_q;
  assign running   = (r_state == RUN);
  assign gen_count = r_gen;

endmodule

// File: tb/tb_eca_engine.sv
// Bench for eca_engine: reference model feeds a scoreboard for the TICK_DIV=1
// instance, a TICK_DIV=4 instance covers the prescaler.
module tb_eca_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0, start_stop = 1'b0, step = 1'b0, wrap = 1'b0;
  logic [7:0]  rule = 8'd90;
  logic [15:0] data = '0;
  logic [15:0] q1, q4, gen1, gen4;
  logic        run1, run4;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] q;
    logic        run;
    logic [15:0] gen;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_q, m_gen;
  logic        m_run, m_ssd, m_stepd;
  logic [15:0] g0;

  always #5 clk = ~clk;

  eca_engine #(.WIDTH(16), .TICK_DIV(1), .GEN_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .start_stop(start_stop),
    .step(step), .rule(rule), .wrap(wrap), .data(data),
    .q(q1), .running(run1), .gen_count(gen1)
  );

  eca_engine #(.WIDTH(16), .TICK_DIV(4), .GEN_W(16)) dut4 (
    .clk(clk), .rst(rst), .load(load), .start_stop(start_stop),
    .step(step), .rule(rule), .wrap(wrap), .data(data),
    .q(q4), .running(run4), .gen_count(gen4)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_gen(logic [15:0] r, logic [7:0] ru,
                                          logic w);
    logic [15:0] n;
    logic l, c, rr;
    for (int i = 0; i < 16; i++) begin
      l  = (i == 15) ? (w ? r[0] : 1'b0) : r[i+1];
      c  = r[i];
      rr = (i == 0) ? (w ? r[15] : 1'b0) : r[i-1];
      n[i] = ru[{l, c, rr}];
    end
    return n;
  endfunction

  task automatic model_reset();
    m_q = '0; m_gen = '0; m_run = 1'b0; m_ssd = 1'b0; m_stepd = 1'b0;
  endtask

  task automatic model_edge();
    logic ssr, str;
    exp_t e;
    ssr = start_stop & ~m_ssd;
    str = step & ~m_stepd;
    if (load) begin
      m_q = data; m_gen = '0; m_run = 1'b0;
    end else if (ssr) begin
      m_run = ~m_run;
    end else if (m_run || str) begin
      m_q = ref_gen(m_q, rule, wrap);
      m_gen = m_gen + 16'd1;
    end
    m_ssd = start_stop;
    m_stepd = step;
    e.q = m_q; e.run = m_run; e.gen = m_gen;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("sb_q", q1, e.q);
      chk("sb_run", run1, e.run);
      chk("sb_gen", gen1, e.gen);
    end
  endtask

  initial begin
    model_reset();
    // T1: reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      load = i[0]; start_stop = i[1]; step = ~i[0];
      data = 16'hBEEF; rule = 8'hFF; wrap = i[1];
      @(posedge clk); #1;
    end
    chk("rst_q", q1, 0);
    chk("rst_run", run1, 0);
    chk("rst_gen", gen1, 0);
    chk("rst_q4", q4, 0);
    load = 0; start_stop = 0; step = 0; rule = 8'd90; wrap = 0;
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    chk("post_rst_q", q1, 0);

    // T2: rule 90 run from a single cell
    data = 16'h0100; load = 1; tick();
    load = 0; start_stop = 1; tick();
    chk("t2_running", run1, 1);
    start_stop = 0; tick();
    chk("t2_q1", q1, 16'h0280);
    chk("t2_g1", gen1, 1);
    tick();
    chk("t2_q2", q1, 16'h0440);
    chk("t2_g2", gen1, 2);
    start_stop = 1; tick();
    start_stop = 0; tick();
    chk("t2_paused", run1, 0);

    // T3: boundary handling with single steps
    data = 16'h0001; load = 1; tick();
    load = 0; step = 1; tick();
    step = 0; tick();
    chk("t3_nowrap", q1, 16'h0002);
    wrap = 1; load = 1; tick();
    load = 0; step = 1; tick();
    step = 0; tick();
    chk("t3_wrap", q1, 16'h8002);

    // T4: held step acts once; step ignored while running
    data = 16'h1234; rule = 8'd30; wrap = 0; load = 1; tick();
    load = 0; g0 = gen1;
    step = 1;
    repeat (5) tick();
    step = 0; tick();
    chk("t4_held", gen1, g0 + 16'd1);
    start_stop = 1; tick();
    start_stop = 0; g0 = gen1;
    for (int i = 0; i < 6; i++) begin
      step = i[0]; tick();
    end
    step = 0;
    chk("t4_run_step", gen1, g0 + 16'd6);
    start_stop = 1; tick();
    start_stop = 0; tick();

    // T5: prescaler on the TICK_DIV=4 instance, identity rule
    rule = 8'hCC; data = 16'hA5C3; load = 1; tick();
    load = 0; start_stop = 1; tick();
    start_stop = 0;
    repeat (12) tick();
    chk("t5_q4", q4, 16'hA5C3);
    chk("t5_gen4", gen4, 3);
    chk("t5_run4", run4, 1);
    load = 1; tick();
    load = 0; start_stop = 1; tick();
    start_stop = 0;
    repeat (5) tick();
    start_stop = 1; tick();
    start_stop = 0;
    repeat (6) tick();
    chk("t5_frozen", gen4, 1);
    chk("t5_paused4", run4, 0);

    // T6: load beats a start_stop rise; async reset mid-run
    rule = 8'd90; data = 16'h0F0F; load = 1; start_stop = 1; tick();
    chk("t6_q", q1, 16'h0F0F);
    chk("t6_run", run1, 0);
    load = 0; start_stop = 0; tick();
    start_stop = 1; tick();
    start_stop = 0; tick(); tick();
    chk("t6_running", run1, 1);
    #3 rst = 1'b0;
    #1;
    chk("t6_async_q", q1, 0);
    chk("t6_async_run", run1, 0);
    chk("t6_async_gen", gen1, 0);
    chk("t6_async_q4", q4, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t6_after_q", q1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
